asg_dac_slew: RTL and testbench

Output conditioning stage placed directly downstream of one ASG channel, between its 14-bit signed DAC sample and the DAC output mux. Limits the rate of change of the output to a programmable step per programmable tick, and performs click-free mute/unmute by ramping to and from zero. Bypasses to a one-register pass-through when slew limiting is disabled.

---
 rtl/asg_pkg.sv | 13 +
 rtl/asg_tick_div.sv | 26 ++
 rtl/asg_dac_slew.sv | 99 +++++++++
 tb/tb_asg_dac_slew.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// Shared definitions for the ASG output-conditioning blocks: sample width and
// the slew-limiter mute state machine encoding.
package asg_pkg;

    localparam int ASG_DW = 14;

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        MUTING = 2'd1,
        MUTED  = 2'd2
    } asg_state_t;

endpackage : asg_pkg

// File: rtl/asg_tick_div.sv
// Programmable tick generator: tick_o is high whenever the down-counter is at zero,
// and the counter then reloads from set_div_i, so a new period applies at the next reload.
module asg_tick_div #(
    parameter int DIVW = 16
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic [DIVW-1:0] set_div_i,
    output logic            tick_o
);

    logic [DIVW-1:0] cnt_q;

    assign tick_o = (cnt_q == '0);

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= set_div_i;
        end else begin
            cnt_q <= cnt_q - DIVW'(1);
        end
    end

endmodule : asg_tick_div

// File: rtl/asg_dac_slew.sv
// Slew-rate limiter with click-free mute for one ASG DAC channel; a zero step size
// turns the block into a single-register pass-through.
module asg_dac_slew
    import asg_pkg::*;
#(
    parameter int DW   = ASG_DW,
    parameter int DIVW = 16
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic [DW-1:0]   dac_i,
    input  logic [DW-1:0]   set_slew_i,
    input  logic [DIVW-1:0] set_div_i,
    input  logic            mute_i,
    output logic [DW-1:0]   dac_o,
    output logic            muted_o,
    output logic            slewing_o
);

    asg_state_t    state_q, state_d;
    logic [DW-1:0] dac_q, dac_d;
    logic          slewing_q, slewing_d;
    logic          muted_q;
    logic          tick;
    logic          update;
    logic [DW-1:0] target;
    logic [DW:0]   dac_ext, target_ext, slew_ext;
    logic [DW:0]   diff, abs_diff, step_sum;

    asg_tick_div #(.DIVW(DIVW)) u_tick_div (
        .dac_clk_i (dac_clk_i),
        .dac_rst_i (dac_rst_i),
        .set_div_i (set_div_i),
        .tick_o    (tick)
    );

    // One extra bit keeps target-minus-current exact even for a full-scale swing,
    // and a step toward the target can never pass it, so no saturation is needed.
    always_comb begin
        target     = (state_q == TRACK) ? dac_i : '0;
        dac_ext    = {dac_q[DW-1], dac_q};
        target_ext = {target[DW-1], target};
        slew_ext   = {1'b0, set_slew_i};
        diff       = target_ext - dac_ext;
        abs_diff   = diff[DW] ? ('0 - diff) : diff;
        step_sum   = diff[DW] ? (dac_ext - slew_ext) : (dac_ext + slew_ext);

        dac_d     = dac_q;
        slewing_d = slewing_q;
        update    = 1'b0;
        if (set_slew_i == '0) begin
            update    = 1'b1;
            dac_d     = target;
            slewing_d = 1'b0;
        end else if (tick) begin
            update = 1'b1;
            if (abs_diff <= slew_ext) begin
                dac_d     = target;
                slewing_d = 1'b0;
            end else begin
                dac_d     = step_sum[DW-1:0];
                slewing_d = 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            TRACK:   if (mute_i) state_d = MUTING;
            MUTING: begin
                if (!mute_i) begin
                    state_d = TRACK;
                end else if (update && (dac_d == '0)) begin
                    state_d = MUTED;
                end
            end
            MUTED:   if (!mute_i) state_d = TRACK;
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q   <= TRACK;
            dac_q     <= '0;
            slewing_q <= 1'b0;
            muted_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dac_q     <= dac_d;
            slewing_q <= slewing_d;
            muted_q   <= (state_d == MUTED);
        end
    end

    assign dac_o     = dac_q;
    assign muted_o   = muted_q;
    assign slewing_o = slewing_q;

endmodule : asg_dac_slew

// File: tb/tb_asg_dac_slew.sv
// Directed self-checking bench for asg_dac_slew: bypass, step limiting, divider,
// mute/unmute, full-scale swing and reset in the middle of a ramp.
module tb_asg_dac_slew;

    logic        clk;
    logic        rst;
    logic [13:0] dac_i;
    logic [13:0] set_slew;
    logic [15:0] set_div;
    logic        mute;
    logic [13:0] dac_o;
    logic        muted_o;
    logic        slewing_o;

    int checks;
    int errors;

    asg_dac_slew dut (
        .dac_clk_i  (clk),
        .dac_rst_i  (rst),
        .dac_i      (dac_i),
        .set_slew_i (set_slew),
        .set_div_i  (set_div),
        .mute_i     (mute),
        .dac_o      (dac_o),
        .muted_o    (muted_o),
        .slewing_o  (slewing_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bypass for a few cycles so dac_o lands on v and the divider (div=0) is at zero.
    task automatic settle(input int v);
        set_slew = '0;
        set_div  = '0;
        mute     = 1'b0;
        dac_i    = 14'(v);
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; dac_i = 14'd123; set_slew = '0; set_div = '0; mute = 1'b0;
        repeat (3) step();
        checks++;
        if (dac_o !== 14'd0 || muted_o !== 1'b0 || slewing_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: dac_o=%0d muted=%b slewing=%b, required 0/0/0",
                     $signed(dac_o), muted_o, slewing_o);
        end
        rst = 1'b0;
        step();
        checks++;
        if (dac_o !== 14'd123) begin
            errors++;
            $display("FAIL reset_release: dac_o=%0d required 123", $signed(dac_o));
        end
        $display("reset: dac_o=%0d muted=%b slewing=%b", $signed(dac_o), muted_o, slewing_o);
    endtask

    task automatic test_bypass();
        settle(0);
        for (int i = 0; i <= 100; i++) begin
            dac_i = 14'(i);
            step();
            checks++;
            if (dac_o !== 14'(i) || slewing_o !== 1'b0) begin
                errors++;
                $display("FAIL bypass[%0d]: dac_o=%0d slewing=%b, required %0d/0",
                         i, $signed(dac_o), slewing_o, i);
            end
        end
        $display("bypass: ramp 0..100 done, dac_o=%0d", $signed(dac_o));
    endtask

    task automatic test_step_limit();
        settle(0);
        set_slew = 14'd100;
        dac_i    = 14'd1000;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (dac_o !== 14'(100 * k) || slewing_o !== (k <= 9)) begin
                errors++;
                $display("FAIL step_limit[%0d]: dac_o=%0d slewing=%b, required %0d/%0b",
                         k, $signed(dac_o), slewing_o, 100 * k, (k <= 9));
            end
            $display("step_limit: update %0d dac_o=%0d slewing=%b", k, $signed(dac_o), slewing_o);
        end
    endtask

    task automatic test_bypass_switch();
        settle(0);
        set_slew = 14'd100;
        dac_i    = 14'd1000;
        repeat (3) step();
        set_slew = '0;
        step();
        checks++;
        if (dac_o !== 14'd1000 || slewing_o !== 1'b0) begin
            errors++;
            $display("FAIL bypass_switch: dac_o=%0d slewing=%b, required 1000/0",
                     $signed(dac_o), slewing_o);
        end
        $display("bypass_switch: dac_o=%0d", $signed(dac_o));
    endtask

    task automatic test_divider();
        int exp_v;
        int nupd;
        settle(0);
        set_div  = 16'd3;
        set_slew = 14'd10;
        dac_i    = -14'sd50;
        exp_v = 0;
        nupd  = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if ((e - 1) % 4 == 0) begin
                nupd++;
                exp_v = (exp_v - 10 < -50) ? -50 : exp_v - 10;
            end
            checks++;
            if (dac_o !== 14'(exp_v) || slewing_o !== (nupd < 5)) begin
                errors++;
                $display("FAIL divider[%0d]: dac_o=%0d slewing=%b, required %0d/%0b",
                         e, $signed(dac_o), slewing_o, exp_v, (nupd < 5));
            end
            $display("divider: cycle %0d dac_o=%0d", e, $signed(dac_o));
        end
    endtask

    task automatic test_mute();
        int exp_mute[5] = '{500, 300, 100, 0, 0};
        int exp_unm[4]  = '{0, 200, 400, 500};
        settle(500);
        set_slew = 14'd200;
        mute     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (dac_o !== 14'(exp_mute[k]) || muted_o !== (k >= 3)) begin
                errors++;
                $display("FAIL mute[%0d]: dac_o=%0d muted=%b, required %0d/%0b",
                         k, $signed(dac_o), muted_o, exp_mute[k], (k >= 3));
            end
            $display("mute: cycle %0d dac_o=%0d muted=%b", k, $signed(dac_o), muted_o);
        end
        mute = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (dac_o !== 14'(exp_unm[k]) || muted_o !== 1'b0) begin
                errors++;
                $display("FAIL unmute[%0d]: dac_o=%0d muted=%b, required %0d/0",
                         k, $signed(dac_o), muted_o, exp_unm[k]);
            end
            $display("unmute: cycle %0d dac_o=%0d muted=%b", k, $signed(dac_o), muted_o);
        end
    endtask

    task automatic test_full_scale();
        settle(-8192);
        checks++;
        if (dac_o !== 14'h2000) begin
            errors++;
            $display("FAIL full_scale_start: dac_o=%0d required -8192", $signed(dac_o));
        end
        set_slew = 14'd16383;
        dac_i    = 14'd8191;
        step();
        checks++;
        if (dac_o !== 14'd8191 || slewing_o !== 1'b0) begin
            errors++;
            $display("FAIL full_scale_up: dac_o=%0d slewing=%b, required 8191/0",
                     $signed(dac_o), slewing_o);
        end
        $display("full_scale: up dac_o=%0d", $signed(dac_o));
        dac_i = 14'h2000;
        step();
        checks++;
        if (dac_o !== 14'h2000 || slewing_o !== 1'b0) begin
            errors++;
            $display("FAIL full_scale_down: dac_o=%0d slewing=%b, required -8192/0",
                     $signed(dac_o), slewing_o);
        end
        $display("full_scale: down dac_o=%0d", $signed(dac_o));
    endtask

    task automatic test_reset_mid_ramp();
        settle(0);
        set_slew = 14'd100;
        dac_i    = 14'd1000;
        repeat (7) step();
        checks++;
        if (dac_o !== 14'd700 || slewing_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_ramp_pre: dac_o=%0d slewing=%b, required 700/1",
                     $signed(dac_o), slewing_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dac_o !== 14'd0 || muted_o !== 1'b0 || slewing_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_ramp_reset: dac_o=%0d muted=%b slewing=%b, required 0/0/0",
                     $signed(dac_o), muted_o, slewing_o);
        end
        step();
        checks++;
        if (dac_o !== 14'd100 || slewing_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_ramp_restart: dac_o=%0d slewing=%b, required 100/1",
                     $signed(dac_o), slewing_o);
        end
        $display("reset_mid_ramp: restart dac_o=%0d", $signed(dac_o));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; dac_i = '0; set_slew = '0; set_div = '0; mute = 1'b0;
        test_reset();
        test_bypass();
        test_step_limit();
        test_bypass_switch();
        test_divider();
        test_mute();
        test_full_scale();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_asg_dac_slew
